// File: rtl/anc_sequencer_if.sv
// Handshake bundle between the ANC sequencer, the sample strobe logic and the LMS/FIR stages.
// master = environment side (strobes, dones, FIR result); slave = the sequencer.
interface anc_sequencer_if #(
    parameter int OVR_CNT_W = 8
);
    logic                 sample_valid_in;
    logic                 adapt_en_in;
    logic                 lms_start_out;
    logic                 lms_done_in;
    logic                 fir_start_out;
    logic                 fir_done_in;
    logic signed [15:0]   fir_y_in;
    logic signed [15:0]   y_out;
    logic                 y_valid_out;
    logic                 busy_out;
    logic                 overrun_out;
    logic [OVR_CNT_W-1:0] overrun_cnt_out;
    logic                 clear_ovr_in;
    logic                 timeout_out;

    modport master (
        output sample_valid_in, adapt_en_in, lms_done_in, fir_done_in, fir_y_in, clear_ovr_in,
        input  lms_start_out, fir_start_out, y_out, y_valid_out, busy_out,
               overrun_out, overrun_cnt_out, timeout_out
    );

    modport slave (
        input  sample_valid_in, adapt_en_in, lms_done_in, fir_done_in, fir_y_in, clear_ovr_in,
        output lms_start_out, fir_start_out, y_out, y_valid_out, busy_out,
               overrun_out, overrun_cnt_out, timeout_out
    );
endinterface

// File: rtl/anc_sequencer.sv
// Per-sample ANC controller: LMS update then FIR pass, one-deep pending slot, overrun accounting.
// Optional stage watchdog enabled by defining ANC_WATCHDOG_EN.
//
// state       | meaning
// IDLE        | waiting for a strobe or a pending sample
// LMS_START   | one-cycle LMS start pulse
// LMS_WAIT    | waiting for lms_done_in
// FIR_START   | one-cycle FIR start pulse
// FIR_WAIT    | waiting for fir_done_in, result captured on done
// OUTPUT      | one-cycle y_valid_out pulse
module anc_sequencer #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int OVR_CNT_W      = 8
) (
    input  logic           clk_in,
    input  logic           rst_in,
    anc_sequencer_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_LMS_START, S_LMS_WAIT, S_FIR_START, S_FIR_WAIT, S_OUTPUT
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic                 r_pending;
    logic                 w_pending_next;
    logic signed [15:0]   r_y;
    logic                 r_ovr;
    logic [OVR_CNT_W-1:0] r_ovr_cnt;
    logic                 w_start;
    logic                 w_ovr_evt;
    logic                 w_timeout;

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    assign w_start   = (r_state == S_IDLE) && (bus.sample_valid_in || r_pending);
    assign w_ovr_evt = (r_state != S_IDLE) && bus.sample_valid_in && r_pending;

`ifdef ANC_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] r_wd_cnt;
    logic            r_timeout;

    // Counter is zero in the START states, so each WAIT begins its count fresh.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in)
            r_wd_cnt <= '0;
        else if (r_state == S_LMS_WAIT || r_state == S_FIR_WAIT)
            r_wd_cnt <= r_wd_cnt + 1'b1;
        else
            r_wd_cnt <= '0;
    end

    assign w_timeout = (r_wd_cnt == WD_W'(TIMEOUT_CYCLES - 1)) &&
                       ((r_state == S_LMS_WAIT && !bus.lms_done_in) ||
                        (r_state == S_FIR_WAIT && !bus.fir_done_in));

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in)
            r_timeout <= 1'b0;
        else if (bus.clear_ovr_in)
            r_timeout <= 1'b0;
        else if (w_timeout)
            r_timeout <= 1'b1;
    end

    assign bus.timeout_out = r_timeout;
`else
    assign w_timeout       = 1'b0;
    assign bus.timeout_out = 1'b0;
`endif

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:      if (w_start) w_next = bus.adapt_en_in ? S_LMS_START : S_FIR_START;
            S_LMS_START: w_next = S_LMS_WAIT;
            S_LMS_WAIT:  if (bus.lms_done_in) w_next = S_FIR_START;
                         else if (w_timeout) w_next = S_IDLE;
            S_FIR_START: w_next = S_FIR_WAIT;
            S_FIR_WAIT:  if (bus.fir_done_in) w_next = S_OUTPUT;
                         else if (w_timeout) w_next = S_IDLE;
            S_OUTPUT:    w_next = S_IDLE;
            default:     w_next = S_IDLE;
        endcase
    end

    always_comb begin
        bus.lms_start_out = 1'b0;
        bus.fir_start_out = 1'b0;
        bus.y_valid_out   = 1'b0;
        bus.busy_out      = (r_state != S_IDLE);
        case (r_state)
            S_LMS_START: bus.lms_start_out = 1'b1;
            S_FIR_START: bus.fir_start_out = 1'b1;
            S_OUTPUT:    bus.y_valid_out   = 1'b1;
            default:     ;
        endcase
    end

    // A start consumes the slot, but a strobe landing on that same edge refills it.
    always_comb begin
        w_pending_next = r_pending;
        if (w_start)
            w_pending_next = bus.sample_valid_in && r_pending;
        else if (r_state != S_IDLE && bus.sample_valid_in)
            w_pending_next = 1'b1;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_pending <= 1'b0;
            r_y       <= 16'sd0;
        end else begin
            r_pending <= w_pending_next;
            if (r_state == S_FIR_WAIT && bus.fir_done_in)
                r_y <= bus.fir_y_in;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_ovr     <= 1'b0;
            r_ovr_cnt <= '0;
        end else if (bus.clear_ovr_in) begin
            r_ovr     <= 1'b0;
            r_ovr_cnt <= '0;
        end else if (w_ovr_evt) begin
            r_ovr <= 1'b1;
            if (r_ovr_cnt != {OVR_CNT_W{1'b1}})
                r_ovr_cnt <= r_ovr_cnt + 1'b1;
        end
    end

    assign bus.y_out           = r_y;
    assign bus.overrun_out     = r_ovr;
    assign bus.overrun_cnt_out = r_ovr_cnt;
endmodule

// File: tb/tb_anc_sequencer.sv
// Directed self-checking bench for anc_sequencer; watchdog case runs when ANC_WATCHDOG_EN is defined.
module tb_anc_sequencer;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    int   n_lms;
    int   n_fir;
    int   n_yv;
    int   s_lms;
    int   s_fir;
    int   s_yv;

    anc_sequencer_if #(.OVR_CNT_W(8)) bus ();

    anc_sequencer #(.TIMEOUT_CYCLES(16), .OVR_CNT_W(8)) dut (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        n_lms = 0;
        n_fir = 0;
        n_yv  = 0;
    end

    always @(negedge clk) begin
        if (bus.lms_start_out) n_lms++;
        if (bus.fir_start_out) n_fir++;
        if (bus.y_valid_out)   n_yv++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Return both dones immediately until the output pulse appears; leaves the DUT in OUTPUT.
    task automatic finish_seq(input logic [15:0] y);
        logic seen;
        seen = 1'b0;
        bus.lms_done_in = 1'b1;
        bus.fir_done_in = 1'b1;
        bus.fir_y_in    = y;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            if (bus.y_valid_out) seen = 1'b1;
        end
        bus.lms_done_in = 1'b0;
        bus.fir_done_in = 1'b0;
        bus.fir_y_in    = 16'sd0;
        chk("finish_yv", 32'(seen), 32'd1);
        chk("finish_y", 32'($unsigned(bus.y_out)), 32'(y));
    endtask

    initial begin
        #200000;
        $display("FAIL global_time_limit");
        $fatal(1, "time limit");
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        bus.sample_valid_in = 1'b0;
        bus.adapt_en_in     = 1'b0;
        bus.lms_done_in     = 1'b0;
        bus.fir_done_in     = 1'b0;
        bus.fir_y_in        = 16'sd0;
        bus.clear_ovr_in    = 1'b0;
        tick();
        tick();
        chk("rst_y", 32'($unsigned(bus.y_out)), 32'h0);
        chk("rst_busy", 32'(bus.busy_out), 32'd0);
        chk("rst_starts", 32'({bus.lms_start_out, bus.fir_start_out, bus.y_valid_out}), 32'd0);
        chk("rst_ovr", 32'({bus.overrun_out, bus.overrun_cnt_out}), 32'd0);
        chk("rst_timeout", 32'(bus.timeout_out), 32'd0);
        rst = 1'b0;
        tick();

        // adapt on, LMS done 3 cycles late, FIR done 2 cycles late
        s_lms = n_lms; s_fir = n_fir; s_yv = n_yv;
        bus.adapt_en_in = 1'b1;
        bus.sample_valid_in = 1'b1;
        tick();
        bus.sample_valid_in = 1'b0;
        chk("t1_lms_start", 32'(bus.lms_start_out), 32'd1);
        chk("t1_busy", 32'(bus.busy_out), 32'd1);
        tick();
        chk("t1_lms_start_off", 32'(bus.lms_start_out), 32'd0);
        tick();
        tick();
        bus.lms_done_in = 1'b1;
        tick();
        bus.lms_done_in = 1'b0;
        chk("t1_fir_start", 32'(bus.fir_start_out), 32'd1);
        tick();
        tick();
        bus.fir_done_in = 1'b1;
        bus.fir_y_in = 16'sh1234;
        tick();
        bus.fir_done_in = 1'b0;
        bus.fir_y_in = 16'sd0;
        chk("t1_yvalid", 32'(bus.y_valid_out), 32'd1);
        chk("t1_y", 32'($unsigned(bus.y_out)), 32'h1234);
        tick();
        chk("t1_busy_after", 32'(bus.busy_out), 32'd0);
        chk("t1_y_hold", 32'($unsigned(bus.y_out)), 32'h1234);
        tick();
        chk("t1_lms_pulses", 32'(n_lms - s_lms), 32'd1);
        chk("t1_fir_pulses", 32'(n_fir - s_fir), 32'd1);
        chk("t1_yv_pulses", 32'(n_yv - s_yv), 32'd1);

        // adapt off, fir_done held from FIR_START (ignored there) -> y_valid at N+3
        s_lms = n_lms;
        bus.adapt_en_in = 1'b0;
        bus.sample_valid_in = 1'b1;
        tick();
        bus.sample_valid_in = 1'b0;
        chk("t2_fir_start", 32'(bus.fir_start_out), 32'd1);
        bus.fir_done_in = 1'b1;
        bus.fir_y_in = -16'sd5;
        tick();
        chk("t2_no_early_out", 32'(bus.y_valid_out), 32'd0);
        tick();
        bus.fir_done_in = 1'b0;
        bus.fir_y_in = 16'sd0;
        chk("t2_yvalid", 32'(bus.y_valid_out), 32'd1);
        chk("t2_y", 32'($unsigned(bus.y_out)), 32'hFFFB);
        tick();
        chk("t2_no_lms", 32'(n_lms - s_lms), 32'd0);

        // three strobes during LMS_WAIT
        bus.adapt_en_in = 1'b1;
        bus.sample_valid_in = 1'b1;
        tick();
        bus.sample_valid_in = 1'b0;
        tick();
        bus.sample_valid_in = 1'b1;
        tick();
        tick();
        tick();
        bus.sample_valid_in = 1'b0;
        chk("t3_ovr", 32'(bus.overrun_out), 32'd1);
        chk("t3_ovr_cnt", 32'(bus.overrun_cnt_out), 32'd2);
        finish_seq(16'h0042);
        tick();
        chk("t3_idle_gap", 32'(bus.busy_out), 32'd0);
        tick();
        chk("t3_auto_start", 32'(bus.lms_start_out), 32'd1);
        finish_seq(16'h0077);
        tick();
        tick();
        chk("t3_done_idle", 32'(bus.busy_out), 32'd0);
        bus.clear_ovr_in = 1'b1;
        tick();
        bus.clear_ovr_in = 1'b0;
        chk("t3_clear", 32'({bus.overrun_out, bus.overrun_cnt_out}), 32'd0);

        // 300 drops saturate the counter; clear beats a same-cycle overrun
        bus.sample_valid_in = 1'b1;
        for (int i = 0; i < 302; i++) tick();
        chk("t4_sat", 32'(bus.overrun_cnt_out), 32'd255);
        chk("t4_ovr", 32'(bus.overrun_out), 32'd1);
        bus.clear_ovr_in = 1'b1;
        tick();
        bus.clear_ovr_in = 1'b0;
        bus.sample_valid_in = 1'b0;
        chk("t4_clear_wins", 32'({bus.overrun_out, bus.overrun_cnt_out}), 32'd0);
        finish_seq(16'h0100);
        tick();
        bus.sample_valid_in = 1'b1;
        tick();
        bus.sample_valid_in = 1'b0;
        chk("t4_pend_start", 32'(bus.lms_start_out), 32'd1);
        chk("t4_no_ovr", 32'({bus.overrun_out, bus.overrun_cnt_out}), 32'd0);
        finish_seq(16'h0200);
        tick();
        tick();
        chk("t4_recaptured", 32'(bus.lms_start_out), 32'd1);
        finish_seq(16'h0300);
        tick();
        tick();
        chk("t4_idle", 32'(bus.busy_out), 32'd0);

        // strobe during OUTPUT with empty slot
        bus.adapt_en_in = 1'b0;
        bus.sample_valid_in = 1'b1;
        tick();
        bus.sample_valid_in = 1'b0;
        tick();
        bus.fir_done_in = 1'b1;
        bus.fir_y_in = 16'sh0055;
        tick();
        bus.fir_done_in = 1'b0;
        bus.sample_valid_in = 1'b1;
        tick();
        bus.sample_valid_in = 1'b0;
        chk("t5_idle_gap", 32'(bus.busy_out), 32'd0);
        chk("t5_no_ovr", 32'(bus.overrun_out), 32'd0);
        tick();
        chk("t5_next_start", 32'(bus.fir_start_out), 32'd1);
        finish_seq(16'h0066);
        tick();

        // reset in FIR_WAIT, then stray fir_done is ignored
        bus.sample_valid_in = 1'b1;
        tick();
        bus.sample_valid_in = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        chk("t6_rst_busy", 32'(bus.busy_out), 32'd0);
        chk("t6_rst_y", 32'($unsigned(bus.y_out)), 32'h0);
        tick();
        rst = 1'b0;
        bus.fir_done_in = 1'b1;
        bus.fir_y_in = 16'sh7777;
        tick();
        tick();
        bus.fir_done_in = 1'b0;
        bus.fir_y_in = 16'sd0;
        chk("t6_ignored_busy", 32'(bus.busy_out), 32'd0);
        chk("t6_ignored_y", 32'($unsigned(bus.y_out)), 32'h0);
        bus.adapt_en_in = 1'b1;
        bus.sample_valid_in = 1'b1;
        tick();
        bus.sample_valid_in = 1'b0;
        chk("t6_clean_start", 32'(bus.lms_start_out), 32'd1);
        finish_seq(16'h0ABC);
        tick();

        // reset during FIR_START drops the pulse without a clock edge
        bus.adapt_en_in = 1'b0;
        bus.sample_valid_in = 1'b1;
        tick();
        bus.sample_valid_in = 1'b0;
        chk("t7_fir_start", 32'(bus.fir_start_out), 32'd1);
        rst = 1'b1;
        #1;
        chk("t7_async_drop", 32'(bus.fir_start_out), 32'd0);
        tick();
        rst = 1'b0;
        tick();

        // stage watchdog
        s_yv = n_yv;
        bus.adapt_en_in = 1'b1;
        bus.sample_valid_in = 1'b1;
        tick();
        bus.sample_valid_in = 1'b0;
        tick();
`ifdef ANC_WATCHDOG_EN
        for (int i = 0; i < 15; i++) tick();
        chk("wd_still_wait", 32'(bus.busy_out), 32'd1);
        chk("wd_no_early_to", 32'(bus.timeout_out), 32'd0);
        tick();
        chk("wd_idle", 32'(bus.busy_out), 32'd0);
        chk("wd_timeout", 32'(bus.timeout_out), 32'd1);
        chk("wd_y_kept", 32'($unsigned(bus.y_out)), 32'h0);
        tick();
        chk("wd_no_yvalid", 32'(n_yv - s_yv), 32'd0);
        bus.clear_ovr_in = 1'b1;
        tick();
        bus.clear_ovr_in = 1'b0;
        chk("wd_clear", 32'(bus.timeout_out), 32'd0);
`else
        for (int i = 0; i < 20; i++) tick();
        chk("nowd_wait", 32'(bus.busy_out), 32'd1);
        chk("nowd_timeout", 32'(bus.timeout_out), 32'd0);
        finish_seq(16'h0321);
        tick();
        chk("nowd_idle", 32'(bus.busy_out), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/anc_sequencer.md
Name: anc_sequencer

Overview:
Per-sample controller for the adaptive noise-cancelling datapath (sample buffer, error calculator, LMS weight updater, FIR filter).
- On each audio sample strobe it runs the LMS update first, then the FIR pass; each stage is started with a one-cycle pulse and awaits that stage's done.
- Latches the filter output and presents it with a valid strobe.
- Handles strobes that arrive while busy with a one-deep pending slot and overrun accounting.
- Sits between the codec/sample-strobe logic and the lms/fir instances in the top level.

Parameters:
TIMEOUT_CYCLES, 1024, max cycles to wait for a stage done before abort (used only with the optional feature)
OVR_CNT_W, 8, width of saturating overrun counter

Ports:
clk_in  input  1  system clock
rst_in  input  1  reset
sample_valid_in  input  1  one-cycle strobe: new audio sample captured by sampler
adapt_en_in  input  1  1 = run LMS update each sample; 0 = freeze weights (skip LMS)
lms_start_out  output  1  one-cycle pulse starting LMS update
lms_done_in  input  1  LMS finished (level or pulse; sampled only in LMS_WAIT)
fir_start_out  output  1  one-cycle pulse starting FIR pass
fir_done_in  input  1  FIR finished (sampled only in FIR_WAIT)
fir_y_in  input  16 signed  FIR result, valid when fir_done_in high
y_out  output  16 signed  registered filter output to speaker path
y_valid_out  output  1  one-cycle pulse when y_out updated
busy_out  output  1  high in any state other than IDLE
overrun_out  output  1  sticky: a strobe was dropped
overrun_cnt_out  output  OVR_CNT_W  saturating count of dropped strobes
clear_ovr_in  input  1  clears overrun_out and overrun_cnt_out
timeout_out  output  1  sticky stage-timeout flag (tied 0 without the optional feature)

Behaviour:
- Clocking/reset: single clock clk_in; rst_in asynchronous, active-high.
- Reset values: state = IDLE; all outputs 0 (y_out = 16'sd0); pending = 0.
- States:
  - IDLE
  - LMS_START: lms_start_out = 1 for exactly one cycle, then go to LMS_WAIT.
  - LMS_WAIT: lms_done_in = 1 → FIR_START.
  - FIR_START: fir_start_out = 1 for one cycle, then go to FIR_WAIT.
  - FIR_WAIT: fir_done_in = 1 → OUTPUT, capturing fir_y_in into y_out on that edge.
  - OUTPUT: y_valid_out = 1 for one cycle, then go to IDLE.
- Start from IDLE:
  - On sample_valid_in, or pending = 1, go to LMS_START if adapt_en_in = 1, else FIR_START.
  - A start consumes pending (pending cleared).
- adapt_en_in is sampled only at the IDLE decision; changing it mid-sequence has no effect on the current sample.
- Minimum latency, strobe at edge N:
  - adapt on: lms_start at N+1; with done returned in the same cycle → fir_start at N+3; with fir_done returned in the same cycle → y_valid at N+5.
  - adapt off: y_valid at N+3.
- Strobe while busy:
  - pending = 0 → set pending.
  - pending = 1 → drop the strobe; set overrun_out; increment overrun_cnt_out, saturating at all-ones.
- Strobe in OUTPUT with pending = 0 → pending set; the next sample starts from IDLE on the following cycle.
- Same-cycle events:
  - clear_ovr_in together with an overrun event: clear wins, so the counter and flag stay 0.
  - sample_valid_in together with IDLE→start on pending = 1: pending stays 1 (new strobe re-captured), no overrun.
- done inputs outside their WAIT state are ignored.
- y_out holds its value between updates.
- Reset mid-sequence: immediate return to IDLE; start pulses deassert asynchronously; pending and y_out cleared.

Optional Feature:
ANC_WATCHDOG_EN.
- Defined:
  - A cycle counter runs in LMS_WAIT and FIR_WAIT and is cleared on entering either state.
  - If it reaches TIMEOUT_CYCLES without the matching done: set sticky timeout_out and go to IDLE without y_valid_out; y_out keeps its old value.
  - pending is preserved.
  - timeout_out is cleared by clear_ovr_in.
- Undefined: no counter; the WAIT states wait indefinitely; timeout_out tied 0.

Test Plan:
- Reset, then strobe with adapt_en_in = 1; LMS done 3 cycles after lms_start; fir_done with fir_y_in = 16'sh1234 two cycles after fir_start → exactly one lms_start pulse, one fir_start pulse, y_out = 0x1234 with one y_valid pulse, busy low afterwards.
- adapt_en_in = 0, strobe, immediate fir_done with fir_y_in = -5 → no lms_start, y_valid 3 cycles after strobe, y_out = -5.
- While LMS_WAIT, issue 3 strobes → first sets pending; overrun_out = 1, overrun_cnt_out = 2; after completion a second sequence runs automatically.
- 300 dropped strobes with OVR_CNT_W = 8 → overrun_cnt_out saturates at 255; clear_ovr_in → 0 and overrun_out = 0.
- Assert rst_in during FIR_WAIT → outputs 0 immediately; a later fir_done_in is ignored; next strobe starts a clean sequence.
- ANC_WATCHDOG_EN, TIMEOUT_CYCLES = 16, lms_done never asserted → timeout_out = 1, state IDLE 16 cycles after entering LMS_WAIT, no y_valid, y_out unchanged.
